// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame geometry, default bit timing.
package uart_pkg;

    localparam int unsigned DATA_BITS            = 8;
    localparam int unsigned CLKS_PER_BIT_DEFAULT = 10417;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the idle-high serial line; resets to the idle level.
module uart_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: mid-bit sampling, single-byte holding register with ack,
// frame-error and overrun pulses, and break detection on a held-low line.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rxd,
    input  logic                 rx_ack,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_busy,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    logic                 rxs;
    rx_state_e            state, state_nx;
    logic [CNT_W-1:0]     cnt, cnt_nx;
    logic [BIT_W-1:0]     bit_idx, bit_idx_nx;
    logic [DATA_BITS-1:0] shreg, shreg_nx;
    logic [DATA_BITS-1:0] rx_data_nx;
    logic                 rx_valid_nx;
    logic                 frame_err_nx;
    logic                 overrun_nx;

    uart_sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rxd),
        .q     (rxs)
    );

    // State, datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            rx_busy   <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            bit_idx   <= bit_idx_nx;
            shreg     <= shreg_nx;
            rx_data   <= rx_data_nx;
            rx_valid  <= rx_valid_nx;
            rx_busy   <= (state_nx != ST_IDLE);
            frame_err <= frame_err_nx;
            overrun   <= overrun_nx;
        end
    end

    // Next-state, bit timing and delivery
    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        bit_idx_nx   = bit_idx;
        shreg_nx     = shreg;
        rx_data_nx   = rx_data;
        rx_valid_nx  = rx_valid;
        frame_err_nx = 1'b0;
        overrun_nx   = 1'b0;

        if (rx_valid && rx_ack) begin
            rx_valid_nx = 1'b0;
        end

        case (state)
            ST_IDLE: begin
                cnt_nx     = '0;
                bit_idx_nx = '0;
                if (!rxs) begin
                    state_nx = ST_START;
                end
            end
            ST_START: begin
                if (cnt == CNT_HALF) begin
                    cnt_nx   = '0;
                    state_nx = rxs ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_nx     = '0;
                    shreg_nx   = {rxs, shreg[DATA_BITS-1:1]};
                    bit_idx_nx = bit_idx + BIT_W'(1);
                    if (bit_idx == BIT_LAST) begin
                        state_nx = ST_STOP;
                    end
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (cnt == CNT_LAST) begin
                    cnt_nx = '0;
                    if (rxs) begin
                        state_nx = ST_IDLE;
                        // Same-cycle ack frees the holding register for the new byte
                        if (!rx_valid || rx_ack) begin
                            rx_data_nx  = shreg;
                            rx_valid_nx = 1'b1;
                        end else begin
                            overrun_nx = 1'b1;
                        end
                    end else begin
                        frame_err_nx = 1'b1;
                        state_nx     = ST_BREAK;
                    end
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            ST_BREAK: begin
                cnt_nx = '0;
                if (rxs) begin
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: directed frames against a cycle-level event model of
// the receiver's externally visible behaviour, plus literal spot checks.
module tb_uart_receiver;

    localparam int CPB_I  = 16;
    localparam int T_DET  = 3;                          // sync (2) + idle detect edge
    localparam int T_MID  = T_DET + (CPB_I - 1) / 2 + 1; // start-bit mid sample
    localparam int T_STOP = T_MID + 9 * CPB_I;          // stop-bit sample edge
    localparam int NEVER  = 2147483647;

    logic       clk, rst_n, rxd, rx_ack;
    logic [7:0] rx_data;
    logic       rx_valid, rx_busy, frame_err, overrun;

    uart_receiver #(.CLKS_PER_BIT(CPB_I)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rxd       (rxd),
        .rx_ack    (rx_ack),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_busy   (rx_busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Frame descriptor written by stimulus, read by the model
    int         cyc      = 0;
    int         last_rst = -1;
    int         fr_k     = -100000;
    int         fr_end   = -100000;
    logic [7:0] fr_byte  = 8'h00;
    logic       fr_stop  = 1'b1;
    logic       fr_glitch = 1'b0;

    logic [7:0] exp_data  = 8'h00;
    logic       exp_valid = 1'b0;
    logic       exp_busy  = 1'b0;
    logic       exp_ferr  = 1'b0;
    logic       exp_ovr   = 1'b0;

    int   ferr_cnt   = 0;
    int   ovr_cnt    = 0;
    int   vrise_cyc  = -1;
    logic valid_prev = 1'b0;

    // Model: what the outputs must be after each rising edge
    always @(posedge clk) begin
        int   c;
        logic live;
        c    = cyc + 1;
        live = (fr_k > last_rst);
        cyc <= c;
        if (!rst_n) begin
            last_rst  <= c;
            exp_data  <= 8'h00;
            exp_valid <= 1'b0;
            exp_busy  <= 1'b0;
            exp_ferr  <= 1'b0;
            exp_ovr   <= 1'b0;
        end else begin
            exp_ferr <= 1'b0;
            exp_ovr  <= 1'b0;
            if (live && !fr_glitch && c == fr_k + T_STOP) begin
                if (!fr_stop) begin
                    exp_ferr <= 1'b1;
                end else if (!exp_valid || rx_ack) begin
                    exp_data  <= fr_byte;
                    exp_valid <= 1'b1;
                end else begin
                    exp_ovr <= 1'b1;
                end
            end else if (exp_valid && rx_ack) begin
                exp_valid <= 1'b0;
            end
            exp_busy <= live && (c >= fr_k + T_DET) && (c < fr_end);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("rx_data",   32'(rx_data),   32'(exp_data));
                chk("rx_valid",  32'(rx_valid),  32'(exp_valid));
                chk("rx_busy",   32'(rx_busy),   32'(exp_busy));
                chk("frame_err", 32'(frame_err), 32'(exp_ferr));
                chk("overrun",   32'(overrun),   32'(exp_ovr));
                if (frame_err) ferr_cnt++;
                if (overrun)   ovr_cnt++;
                if (rx_valid && !valid_prev) vrise_cyc = cyc;
            end
            valid_prev = rx_valid;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ack_pulse();
        @(posedge clk); #1; rx_ack = 1'b1;
        @(posedge clk); #1; rx_ack = 1'b0;
    endtask

    // Drives one 10-bit frame; optional ack on the stop-sample cycle and reset mid-frame
    task automatic send_frame(input logic [7:0] b, input logic stop,
                              input bit ack_at_stop, input int abort_at);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        @(posedge clk); #1;
        fr_k      = cyc;
        fr_byte   = b;
        fr_stop   = stop;
        fr_glitch = 1'b0;
        fr_end    = stop ? cyc + T_STOP : NEVER;
        rxd       = 1'b0;
        for (int j = 1; j < 10 * CPB_I; j++) begin
            @(posedge clk); #1;
            rxd = bits[j / CPB_I];
            if (ack_at_stop) rx_ack = (j == T_STOP - 1);
            if (abort_at != 0 && j == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk("abort_rx_data",  32'(rx_data),  32'h00);
                chk("abort_rx_valid", 32'(rx_valid), 32'h0);
                chk("abort_rx_busy",  32'(rx_busy),  32'h0);
            end
            if (abort_at != 0 && j == abort_at + 2) rst_n = 1'b1;
        end
    endtask

    task automatic glitch(input int low_cycles);
        @(posedge clk); #1;
        fr_k      = cyc;
        fr_glitch = 1'b1;
        fr_end    = cyc + T_MID;
        rxd       = 1'b0;
        idle(low_cycles);
        rxd = 1'b1;
    endtask

    initial begin
        int f0, o0;
        clk    = 1'b0;
        rst_n  = 1'b0;
        rxd    = 1'b1;
        rx_ack = 1'b0;
        fork
            compare_loop();
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_rx_data",   32'(rx_data),   32'h00);
        chk("reset_rx_valid",  32'(rx_valid),  32'h0);
        chk("reset_rx_busy",   32'(rx_busy),   32'h0);
        chk("reset_frame_err", 32'(frame_err), 32'h0);
        chk("reset_overrun",   32'(overrun),   32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(4);

        // Good frame, held until acknowledged
        send_frame(8'hA5, 1'b1, 1'b0, 0);
        idle(5);
        @(negedge clk);
        chk("a5_data",    32'(rx_data),  32'hA5);
        chk("a5_valid",   32'(rx_valid), 32'h1);
        chk("a5_latency_in_150_160",
            32'((vrise_cyc - fr_k >= 150) && (vrise_cyc - fr_k <= 160)), 32'h1);
        ack_pulse();
        idle(3);
        @(negedge clk);
        chk("a5_acked_valid", 32'(rx_valid), 32'h0);

        // Short low glitch is rejected
        f0 = ferr_cnt;
        o0 = ovr_cnt;
        glitch(4);
        idle(20);
        @(negedge clk);
        chk("glitch_valid", 32'(rx_valid),       32'h0);
        chk("glitch_busy",  32'(rx_busy),        32'h0);
        chk("glitch_data",  32'(rx_data),        32'hA5);
        chk("glitch_ferr",  32'(ferr_cnt - f0),  32'd0);
        chk("glitch_ovr",   32'(ovr_cnt - o0),   32'd0);

        // Bad stop bit followed by a held-low line
        f0 = ferr_cnt;
        send_frame(8'h3C, 1'b0, 1'b0, 0);
        idle(20);
        @(negedge clk);
        chk("break_busy_held", 32'(rx_busy), 32'h1);
        idle(20);
        rxd    = 1'b1;
        fr_end = cyc + T_DET;
        idle(10);
        @(negedge clk);
        chk("break_ferr_pulses", 32'(ferr_cnt - f0), 32'd1);
        chk("break_valid",       32'(rx_valid),      32'h0);
        chk("break_busy_end",    32'(rx_busy),       32'h0);

        // Overrun: second byte lost while first is unacknowledged
        o0 = ovr_cnt;
        send_frame(8'h11, 1'b1, 1'b0, 0);
        idle(2);
        send_frame(8'h22, 1'b1, 1'b0, 0);
        idle(5);
        @(negedge clk);
        chk("ovr_data",   32'(rx_data),      32'h11);
        chk("ovr_valid",  32'(rx_valid),     32'h1);
        chk("ovr_pulses", 32'(ovr_cnt - o0), 32'd1);
        ack_pulse();
        idle(3);

        // Ack coincident with the second stop sample
        o0 = ovr_cnt;
        send_frame(8'h11, 1'b1, 1'b0, 0);
        idle(2);
        send_frame(8'h22, 1'b1, 1'b1, 0);
        idle(5);
        @(negedge clk);
        chk("ackstop_data",  32'(rx_data),      32'h22);
        chk("ackstop_valid", 32'(rx_valid),     32'h1);
        chk("ackstop_ovr",   32'(ovr_cnt - o0), 32'd0);
        ack_pulse();
        idle(3);

        // Reset during the 4th data bit, then a clean frame
        f0 = ferr_cnt;
        send_frame(8'hFF, 1'b1, 1'b0, 4 * CPB_I + CPB_I / 2);
        idle(5);
        @(negedge clk);
        chk("post_abort_valid", 32'(rx_valid), 32'h0);
        chk("post_abort_data",  32'(rx_data),  32'h00);
        send_frame(8'h5A, 1'b1, 1'b0, 0);
        idle(5);
        @(negedge clk);
        chk("resume_data",  32'(rx_data),       32'h5A);
        chk("resume_valid", 32'(rx_valid),      32'h1);
        chk("resume_ferr",  32'(ferr_cnt - f0), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
